mrd_tlp_requester: RTL and testbench
====================================

// Module: mrd_tlp_requester
// PURPOSE
// - Downstream of the gather read DMA: turns each DMA read request (addr/len/valid) into PCIe MemRd 3DW TLP headers.
// - Splits requests at Max Read Request Size (MRRS) and 4 KB boundaries, and assigns one tag per TLP.
// - Tracks outstanding tags until the completion packer frees them.
// - Outputs the tag of the next TLP on current_tag, which upstream latches when it raises valid.
// PARAMETERS
// - TAG_COUNT  32  usable tags 0..TAG_COUNT-1, power of 2, range 2..256
// PORTS
// i_clk             in   1    clock
// i_rst             in   1    reset, synchronous, active-high
// pcie_dcommand     in   16   PCIe device control; bits [14:12] = MRRS code
// requester_id      in   16   bus/dev/fn placed in the header
// dma_read_addr     in   32   byte address, DW aligned
// dma_read_len      in   10   length in DW; 0 means 1024
// dma_read_valid    in   1    request present; held stable until done
// dma_read_done     out  1    1-cycle pulse: all TLPs of the request accepted
// current_tag       out  8    tag that the next TLP will carry
// tag_free_valid    in   1    completion packer finished a tag
// tag_free_tag      in   8    tag being freed
// tx_tdata          out  128  DW0 [31:0], DW1 [63:32], DW2 [95:64], [127:96] = 0
// tx_tkeep          out  16   always 16'h0FFF
// tx_tlast          out  1    always 1 (single-beat header)
// tx_tvalid         out  1    header valid
// tx_tready         in   1    sink accepts
// tags_outstanding  out  9    count of allocated, unfreed tags
// BEHAVIOUR
// - Reset values: dma_read_done=0, tx_tvalid=0, tx_tdata=0, current_tag=0, tags_outstanding=0.
// - Reset also clears the outstanding bitmap and returns the FSM to IDLE, even mid-request.
// - MRRS: code 0..5 gives mrrs_dw = 32<<code. Codes 6 and 7 use 32 DW.
// - Arithmetic: rem and chunk are 11 bits. dw_to_4k = 1024 - addr[11:2].
//   chunk = min(rem, mrrs_dw, dw_to_4k).
// - FSM states:
//   - IDLE: when dma_read_valid is high, latch addr, and rem = (len==0 ? 1024 : len); go to CALC.
//     Inputs are sampled only in IDLE.
//   - CALC: register chunk. If the bitmap bit for current_tag is set, go to WAIT_TAG; else go to SEND.
//   - WAIT_TAG: stay while current_tag is outstanding; then go to SEND.
//   - SEND: build the header registers, drive tx_tvalid=1, hold tdata stable until tx_tready.
//     - DW0 = {fmt 3'b000, type 5'b0, 14'b0, len[9:0] (1024 encodes as 0)}.
//     - DW1 = {requester_id, tag, lastBE, firstBE 4'hF}; lastBE = (chunk==1) ? 4'h0 : 4'hF.
//     - DW2 = {addr[31:2], 2'b00}.
//     - On the accept cycle (tvalid & tready): set the bitmap bit, increment current_tag mod TAG_COUNT,
//       addr += chunk*4, rem -= chunk. If rem becomes 0, go to DONE; else go to CALC.
//   - DONE: pulse dma_read_done for one cycle; go to IDLE. A new request is accepted no earlier than the following cycle.
// - Tag free: on tag_free_valid, clear the bit. Freeing a tag not outstanding or >= TAG_COUNT is ignored.
//   A free and an allocate in the same cycle both apply; tags_outstanding is adjusted by net +1/0/-1.
// - Tags are issued strictly round robin. No skipping: a busy next tag stalls the FSM.
// - Back-to-back throughput: one header every 2 cycles (CALC + SEND) when tags are free and tready=1.
// CONFIGURATION
// - MRD_4K_BOUNDARY_EN defined: dw_to_4k takes part in the chunk min(); no TLP crosses a 4 KB boundary.
// - MRD_4K_BOUNDARY_EN undefined: chunk = min(rem, mrrs_dw); the caller guarantees requests do not cross 4 KB.
// TESTING
// 1. MRRS 2, addr 0x1000_0000, len 256 -> two TLPs: len 128 @0x1000_0000 tag 0, len 128 @0x1000_0200 tag 1;
//    one done pulse after the 2nd accept.
// 2. MRD_4K_BOUNDARY_EN, MRRS 5, addr 0x0000_0FC0, len 32 -> len 16 @0x0FC0, then len 16 @0x1000.
// 3. TAG_COUNT=4, MRRS 0, len 256 -> 4 TLPs (tags 0-3), then tvalid stays low and tags_outstanding=4;
//    free tag 0 -> next TLP carries tag 0 @+0x200.
// 4. len 1 -> DW0 len 1, DW1 BE byte 0x0F.
//    len 0 with MRRS 5, addr 0 -> one TLP, DW0 len field 0 (1024 DW).
// 5. tx_tready low for 5 cycles during SEND -> tx_tdata/tx_tvalid stable; header accepted on the first tready cycle.
// 6. Assert i_rst while a TLP of a 3-TLP request is pending -> tvalid=0, tags_outstanding=0, current_tag=0, no done pulse;
//    a new request starts at tag 0.

Source files
------------

// File: rtl/mrd_tlp_requester.sv
// MemRd 3DW TLP header generator for the gather read DMA.
// Splits each DMA read request at MRRS (and optionally 4 KB) boundaries,
// issues one round-robin tag per TLP and tracks tags until they are freed.
// Optional feature macro: MRD_4K_BOUNDARY_EN (chunks never cross a 4 KB page).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for dma_read_valid; latches the request
// CALC     | computes the next chunk size; checks the next tag is free
// WAIT_TAG | next tag still outstanding; stall until it is freed
// SEND     | header presented on tx_*; held until tx_tready
// DONE     | one-cycle dma_read_done pulse

module mrd_tlp_requester #(
   parameter int unsigned TAG_COUNT = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [15:0]  pcie_dcommand,
   input  logic [15:0]  requester_id,
   input  logic [31:0]  dma_read_addr,
   input  logic [9:0]   dma_read_len,
   input  logic         dma_read_valid,
   output logic         dma_read_done,
   output logic [7:0]   current_tag,
   input  logic         tag_free_valid,
   input  logic [7:0]   tag_free_tag,
   output logic [127:0] tx_tdata,
   output logic [15:0]  tx_tkeep,
   output logic         tx_tlast,
   output logic         tx_tvalid,
   input  logic         tx_tready,
   output logic [8:0]   tags_outstanding
);

   localparam int TW = $clog2(TAG_COUNT);
   localparam logic [TAG_COUNT-1:0] ONE_V = TAG_COUNT'(1);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAIT_TAG, S_SEND, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [10:0]          rem_q, rem_d;
   logic [10:0]          chunk_q, chunk_d;
   logic [2:0]           mrrs_code_q, mrrs_code_d;
   logic [15:0]          rid_q, rid_d;
   logic [7:0]           tag_q, tag_d;
   logic [TAG_COUNT-1:0] bitmap_q, bitmap_d;
   logic [8:0]           cnt_q, cnt_d;
   logic [127:0]         tdata_q, tdata_d;

   logic [10:0]          mrrs_dw;
   logic [10:0]          chunk_c;
   logic [10:0]          hdr_chunk;
   logic [127:0]         hdr_c;
   logic [TW-1:0]        tag_idx;
   logic [TW-1:0]        free_idx;
   logic                 free_hit;
   logic                 alloc;
   logic [TAG_COUNT-1:0] set_vec;
   logic [TAG_COUNT-1:0] clr_vec;
   logic                 unused_ok;

   assign unused_ok = ^{pcie_dcommand[15], pcie_dcommand[11:0]};

   assign tag_idx  = tag_q[TW-1:0];
   assign free_idx = tag_free_tag[TW-1:0];

   // Chunk size for the next TLP: bounded by remaining length, MRRS and (optionally) the 4 KB page.
   always_comb begin
      mrrs_dw = (mrrs_code_q <= 3'd5) ? (11'd32 << mrrs_code_q) : 11'd32;
      chunk_c = (rem_q < mrrs_dw) ? rem_q : mrrs_dw;
`ifdef MRD_4K_BOUNDARY_EN
      if ((11'd1024 - {1'b0, addr_q[11:2]}) < chunk_c)
         chunk_c = 11'd1024 - {1'b0, addr_q[11:2]};
`endif
   end

   // Header contents; in CALC the chunk register is not loaded yet, so use the fresh value.
   always_comb begin
      hdr_chunk = (state_q == S_CALC) ? chunk_c : chunk_q;
      hdr_c     = {32'h0,
                   addr_q[31:2], 2'b00,
                   rid_q, tag_q, (hdr_chunk == 11'd1) ? 4'h0 : 4'hF, 4'hF,
                   3'b000, 5'b00000, 14'h0, hdr_chunk[9:0]};
   end

   // Next-state logic for the request FSM, tag bitmap and outstanding counter.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      chunk_d     = chunk_q;
      mrrs_code_d = mrrs_code_q;
      rid_d       = rid_q;
      tag_d       = tag_q;
      tdata_d     = tdata_q;
      alloc       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dma_read_valid) begin
               addr_d      = dma_read_addr;
               rem_d       = (dma_read_len == 10'd0) ? 11'd1024 : {1'b0, dma_read_len};
               mrrs_code_d = pcie_dcommand[14:12];
               rid_d       = requester_id;
               state_d     = S_CALC;
            end
         end
         S_CALC: begin
            chunk_d = chunk_c;
            if (bitmap_q[tag_idx]) begin
               state_d = S_WAIT_TAG;
            end else begin
               state_d = S_SEND;
               tdata_d = hdr_c;
            end
         end
         S_WAIT_TAG: begin
            if (!bitmap_q[tag_idx]) begin
               state_d = S_SEND;
               tdata_d = hdr_c;
            end
         end
         S_SEND: begin
            if (tx_tready) begin
               alloc   = 1'b1;
               tag_d   = (tag_q == 8'(TAG_COUNT - 1)) ? 8'd0 : tag_q + 8'd1;
               addr_d  = addr_q + {19'h0, chunk_q, 2'b00};
               rem_d   = rem_q - chunk_q;
               state_d = (rem_q == chunk_q) ? S_DONE : S_CALC;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      free_hit = tag_free_valid && ({1'b0, tag_free_tag} < 9'(TAG_COUNT)) && bitmap_q[free_idx];
      set_vec  = alloc    ? (ONE_V << tag_idx)  : '0;
      clr_vec  = free_hit ? (ONE_V << free_idx) : '0;
      bitmap_d = (bitmap_q & ~clr_vec) | set_vec;
      cnt_d    = cnt_q;
      if (alloc && !free_hit)
         cnt_d = cnt_q + 9'd1;
      else if (!alloc && free_hit)
         cnt_d = cnt_q - 9'd1;
   end

   // State and datapath registers; reset abandons any request in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         chunk_q     <= '0;
         mrrs_code_q <= '0;
         rid_q       <= '0;
         tag_q       <= '0;
         bitmap_q    <= '0;
         cnt_q       <= '0;
         tdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         chunk_q     <= chunk_d;
         mrrs_code_q <= mrrs_code_d;
         rid_q       <= rid_d;
         tag_q       <= tag_d;
         bitmap_q    <= bitmap_d;
         cnt_q       <= cnt_d;
         tdata_q     <= tdata_d;
      end
   end

   assign tx_tvalid        = (state_q == S_SEND);
   assign dma_read_done    = (state_q == S_DONE);
   assign tx_tdata         = tdata_q;
   assign tx_tkeep         = 16'h0FFF;
   assign tx_tlast         = 1'b1;
   assign current_tag      = tag_q;
   assign tags_outstanding = cnt_q;

endmodule

// File: tb/tb_mrd_tlp_requester.sv
// Self-checking bench for mrd_tlp_requester with a small tag pool (4 tags)
// so tag stalls are easy to provoke. Expected headers come from a loop that
// splits each request by the MRRS / 4 KB rules.

module tb_mrd_tlp_requester;

   localparam int TC  = 4;
   localparam int TBW = $clog2(TC);
   localparam logic [15:0] RID = 16'hA5C3;

   logic         clk = 1'b0;
   logic         i_rst;
   logic [15:0]  pcie_dcommand;
   logic [15:0]  requester_id;
   logic [31:0]  dma_read_addr;
   logic [9:0]   dma_read_len;
   logic         dma_read_valid;
   logic         dma_read_done;
   logic [7:0]   current_tag;
   logic         tag_free_valid;
   logic [7:0]   tag_free_tag;
   logic [127:0] tx_tdata;
   logic [15:0]  tx_tkeep;
   logic         tx_tlast;
   logic         tx_tvalid;
   logic         tx_tready;
   logic [8:0]   tags_outstanding;

   mrd_tlp_requester #(.TAG_COUNT(TC)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .pcie_dcommand(pcie_dcommand), .requester_id(requester_id),
      .dma_read_addr(dma_read_addr), .dma_read_len(dma_read_len),
      .dma_read_valid(dma_read_valid), .dma_read_done(dma_read_done),
      .current_tag(current_tag),
      .tag_free_valid(tag_free_valid), .tag_free_tag(tag_free_tag),
      .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
      .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
      .tags_outstanding(tags_outstanding)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [127:0] hdr_q[$];
   logic [127:0] exp_q[$];
   int           hdr_rd = 0;
   int           exp_rd = 0;
   int           exp_tag = 0;
   int           done_cnt = 0;
   int           acc_cnt = 0;
   logic [TC-1:0] model_bits = '0;

   // Reference tag bookkeeping: tags are granted in accept order, frees only hit outstanding tags.
   logic          m_accept;
   logic          m_free;
   logic [TC-1:0] m_free_mask;
   logic [TC-1:0] m_alloc_mask;
   assign m_accept     = tx_tvalid && tx_tready;
   assign m_free       = tag_free_valid && (int'(tag_free_tag) < TC) && model_bits[tag_free_tag[TBW-1:0]];
   assign m_free_mask  = m_free ? (TC'(1) << tag_free_tag[TBW-1:0]) : '0;
   assign m_alloc_mask = m_accept ? (TC'(1) << (acc_cnt % TC)) : '0;

   // Monitor on the falling edge: inputs are settled and match what the next rising edge sees.
   always @(negedge clk) begin
      if (i_rst) begin
         model_bits <= '0;
         acc_cnt    <= 0;
      end else begin
         model_bits <= (model_bits & ~m_free_mask) | m_alloc_mask;
         if (m_accept) begin
            hdr_q.push_back(tx_tdata);
            acc_cnt <= acc_cnt + 1;
         end
         if (dma_read_done) done_cnt <= done_cnt + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_hdr(input logic [31:0] a, input int c, input int tag);
      logic [9:0] lf;
      logic [7:0] t8;
      lf = 10'(c);
      t8 = 8'(tag);
      return {32'h0, a[31:2], 2'b00, RID, t8, (c == 1) ? 4'h0 : 4'hF, 4'hF, 22'h0, lf};
   endfunction

   // Expected header list for one request, from the split rules.
   task automatic plan_req(input logic [31:0] addr, input int len, input int code);
      int rem, mrrs, c;
      logic [31:0] a;
      rem  = (len == 0) ? 1024 : len;
      mrrs = (code <= 5) ? (32 << code) : 32;
      a    = addr;
      while (rem > 0) begin
         c = (rem < mrrs) ? rem : mrrs;
`ifdef MRD_4K_BOUNDARY_EN
         if (1024 - int'(a[11:2]) < c) c = 1024 - int'(a[11:2]);
`endif
         exp_q.push_back(mk_hdr(a, c, exp_tag));
         exp_tag = (exp_tag + 1) % TC;
         a   = a + 32'(c * 4);
         rem = rem - c;
      end
   endtask

   task automatic start_req(input logic [31:0] addr, input int len, input int code);
      logic [2:0] c3;
      plan_req(addr, len, code);
      c3             = 3'(code);
      pcie_dcommand  = {1'b0, c3, 12'h5A5};
      requester_id   = RID;
      dma_read_addr  = addr;
      dma_read_len   = 10'(len);
      dma_read_valid = 1'b1;
   endtask

   task automatic drive_free(input bit en);
      int r, s, t;
      logic [7:0] b;
      tag_free_valid = 1'b0;
      tag_free_tag   = 8'd0;
      if (!en) return;
      r = int'($urandom % 4);
      if (r == 0 && model_bits != '0) begin
         s = int'($urandom % TC);
         for (int k = 0; k < TC; k++) begin
            t = (s + k) % TC;
            if (model_bits[t] && !tag_free_valid) begin
               tag_free_valid = 1'b1;
               tag_free_tag   = 8'(t);
            end
         end
      end else if (r == 1) begin
         b = 8'($urandom);
         if (int'(b) < TC && model_bits[b[TBW-1:0]]) b = 8'd200;
         tag_free_valid = 1'b1;
         tag_free_tag   = b;
      end
   endtask

   task automatic finish_req(input string name, input bit rnd_ready, input bit do_free);
      int d0, n_hdr, n_exp, n;
      bit got;
      d0  = done_cnt;
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         tx_tready = rnd_ready ? ($urandom % 3 != 0) : 1'b1;
         drive_free(do_free);
         chk({name, " outstanding"}, 128'(tags_outstanding), 128'($countones(model_bits)));
         chk({name, " current_tag"}, 128'(current_tag), 128'(acc_cnt % TC));
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      tag_free_valid = 1'b0;
      dma_read_valid = 1'b0;
      tx_tready      = 1'b1;
      chk({name, " done_seen"}, 128'(got), 128'(1));
      tick();
      chk({name, " done_pulses"}, 128'(done_cnt - d0), 128'(1));
      n_hdr = hdr_q.size() - hdr_rd;
      n_exp = exp_q.size() - exp_rd;
      chk({name, " tlp_count"}, 128'(n_hdr), 128'(n_exp));
      n = (n_hdr < n_exp) ? n_hdr : n_exp;
      for (int k = 0; k < n; k++)
         chk({name, " header"}, hdr_q[hdr_rd + k], exp_q[exp_rd + k]);
      hdr_rd = hdr_q.size();
      exp_rd = exp_q.size();
   endtask

   task automatic free_all();
      bit f;
      for (int i = 0; i < 50 && model_bits != '0; i++) begin
         tick();
         f = 1'b0;
         tag_free_valid = 1'b0;
         for (int t = 0; t < TC; t++) begin
            if (model_bits[t] && !f) begin
               f = 1'b1;
               tag_free_valid = 1'b1;
               tag_free_tag   = 8'(t);
            end
         end
      end
      tick();
      tag_free_valid = 1'b0;
      tick();
      chk("free_all outstanding", 128'(tags_outstanding), 128'(0));
   endtask

   task automatic wait_hdrs(input string name, input int count);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (hdr_q.size() - hdr_rd >= count) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk({name, " hdr_wait"}, 128'(ok), 128'(1));
   endtask

   initial begin
      logic [127:0] cap, h;
      int d0, base, code, len, eff, dwoff;
      logic [31:0] addr;

      i_rst = 1'b1;
      pcie_dcommand = '0; requester_id = '0; dma_read_addr = '0; dma_read_len = '0;
      dma_read_valid = 1'b0; tag_free_valid = 1'b0; tag_free_tag = '0; tx_tready = 1'b1;
      tick(); tick(); tick();
      i_rst = 1'b0;
      tick();
      chk("rst done", 128'(dma_read_done), 128'(0));
      chk("rst tvalid", 128'(tx_tvalid), 128'(0));
      chk("rst tdata", tx_tdata, 128'(0));
      chk("rst current_tag", 128'(current_tag), 128'(0));
      chk("rst outstanding", 128'(tags_outstanding), 128'(0));
      chk("tkeep", 128'(tx_tkeep), 128'(16'h0FFF));
      chk("tlast", 128'(tx_tlast), 128'(1));

      // Two MRRS-sized TLPs
      start_req(32'h1000_0000, 256, 2);
      finish_req("t1", 1'b0, 1'b0);
      free_all();

      // Request straddling a 4 KB page
      start_req(32'h0000_0FC0, 32, 5);
      finish_req("t2", 1'b0, 1'b0);
      free_all();

      i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;
      exp_tag = 0; hdr_rd = hdr_q.size(); exp_rd = exp_q.size();
      tick();

      // Tag exhaustion stall, then release of tag 0
      start_req(32'h2000_0000, 256, 0);
      tx_tready = 1'b1;
      d0 = done_cnt;
      wait_hdrs("t3", 4);
      for (int i = 0; i < 10; i++) tick();
      chk("t3 stall tvalid", 128'(tx_tvalid), 128'(0));
      chk("t3 stall outstanding", 128'(tags_outstanding), 128'(4));
      chk("t3 stall count", 128'(hdr_q.size() - hdr_rd), 128'(4));
      chk("t3 no done", 128'(done_cnt - d0), 128'(0));
      tag_free_valid = 1'b1; tag_free_tag = 8'd0;
      tick();
      tag_free_valid = 1'b0;
      wait_hdrs("t3b", 5);
      h = hdr_q[hdr_rd + 4];
      chk("t3 fifth tag", 128'(h[47:40]), 128'(0));
      chk("t3 fifth addr", 128'(h[95:64]), 128'(32'h2000_0200));
      finish_req("t3", 1'b0, 1'b1);
      free_all();

      // Single-DW and full-1024-DW lengths
      start_req(32'h3000_0040, 1, 3);
      finish_req("t4a", 1'b0, 1'b0);
      h = hdr_q[hdr_q.size() - 1];
      chk("t4a len", 128'(h[9:0]), 128'(1));
      chk("t4a be", 128'(h[39:32]), 128'(8'h0F));
      start_req(32'h0000_0000, 0, 5);
      finish_req("t4b", 1'b0, 1'b0);
      h = hdr_q[hdr_q.size() - 1];
      chk("t4b len", 128'(h[9:0]), 128'(0));
      free_all();

      // Backpressure while a header is presented
      start_req(32'h4000_0100, 64, 1);
      tx_tready = 1'b0;
      base = hdr_rd;
      for (int i = 0; i < 50 && !tx_tvalid; i++) tick();
      chk("t5 tvalid up", 128'(tx_tvalid), 128'(1));
      cap = tx_tdata;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5 hold tvalid", 128'(tx_tvalid), 128'(1));
         chk("t5 hold tdata", tx_tdata, cap);
      end
      chk("t5 none accepted", 128'(hdr_q.size() - base), 128'(0));
      finish_req("t5", 1'b0, 1'b0);
      chk("t5 first accepted", hdr_q[base], cap);
      free_all();

      // Reset in the middle of a three-TLP request
      start_req(32'h5000_0000, 96, 0);
      tx_tready = 1'b1;
      wait_hdrs("t6", 1);
      tx_tready = 1'b0;
      for (int i = 0; i < 50 && !tx_tvalid; i++) tick();
      d0 = done_cnt;
      i_rst = 1'b1;
      dma_read_valid = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      tx_tready = 1'b1;
      tick();
      chk("t6 tvalid", 128'(tx_tvalid), 128'(0));
      chk("t6 outstanding", 128'(tags_outstanding), 128'(0));
      chk("t6 current_tag", 128'(current_tag), 128'(0));
      for (int i = 0; i < 5; i++) tick();
      chk("t6 no done", 128'(done_cnt - d0), 128'(0));
      exp_tag = 0; hdr_rd = hdr_q.size(); exp_rd = exp_q.size();
      base = hdr_rd;
      start_req(32'h5000_1000, 64, 0);
      finish_req("t6n", 1'b0, 1'b0);
      h = hdr_q[base];
      chk("t6 new tag", 128'(h[47:40]), 128'(0));
      free_all();

      // Random requests with random backpressure and tag frees
      for (int r = 0; r < 12; r++) begin
         code = int'($urandom % 8);
         len  = int'($urandom % 1024);
         eff  = (len == 0) ? 1024 : len;
`ifdef MRD_4K_BOUNDARY_EN
         addr  = $urandom & 32'hFFFF_FFFC;
         dwoff = eff;
`else
         dwoff = int'($urandom % (1025 - eff));
         addr  = ($urandom & 32'hFFFF_F000) | 32'(dwoff * 4);
`endif
         start_req(addr, len, code);
         finish_req("rnd", 1'b1, 1'b1);
      end
      free_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
